// File: rtl/stim_pkg.sv
// Shared encodings for the stimulus pattern generator: step modes, FSM states
// and the seed value restored by reset.
package stim_pkg;

    typedef enum logic [1:0] {
        MODE_ROL  = 2'd0,
        MODE_ROR  = 2'd1,
        MODE_INC  = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SEED_RST = 1;

endpackage

// File: rtl/stim_pattern_step.sv
// Combinational seed update: computes the next pattern word from the current
// seed and the step mode.
module stim_pattern_step
    import stim_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] seed,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_seed
);

    always_comb begin
        // NOTE: default assignment first so every path drives next_seed and no latch is inferred.
        next_seed = seed;
        case (mode)
            MODE_ROL:  next_seed = {seed[WIDTH-2:0], seed[WIDTH-1]};
            MODE_ROR:  next_seed = {seed[0], seed[WIDTH-1:1]};
            MODE_INC:  next_seed = seed + WIDTH'(1);
            MODE_HOLD: next_seed = seed;
            default:   next_seed = seed;
        endcase
    end

endmodule

// File: rtl/stim_pattern_gen.sv
// Burst stimulus source: emits a run of pattern words over a valid/ready
// handshake, stepping a loadable seed after each accepted beat.
module stim_pattern_gen
    import stim_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    output logic [WIDTH-1:0]   number,
    output logic               number_valid,
    input  logic               number_ready,
    output logic               busy,
    output logic               done
);

    // One extra bit so a zero burst_len can hold the full 2**BURST_W count.
    localparam int CNT_W = BURST_W + 1;

    state_e           state;
    mode_e            mode_q;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] next_seed;

    stim_pattern_step #(.WIDTH(WIDTH)) u_step (
        .seed      (number),
        .mode      (mode_q),
        .next_seed (next_seed)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_ROL;
            remaining    <= '0;
            number       <= WIDTH'(SEED_RST);
            number_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        number <= load_data;
                    end
                    if (start) begin
                        mode_q       <= mode_e'(mode);
                        remaining    <= (burst_len == '0) ? {1'b1, {BURST_W{1'b0}}}
                                                          : {1'b0, burst_len};
                        state        <= ST_RUN;
                        number_valid <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (number_valid && number_ready) begin
                        number    <= next_seed;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state        <= ST_DONE;
                            number_valid <= 1'b0;
                            done         <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    number_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Self-checking bench for stim_pattern_gen: a table of short bursts plus
// hand-written reset, backpressure, max-burst and ignored-control sequences.
module tb_stim_pattern_gen;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [7:0] load_data;
    logic [1:0] mode;
    logic       start;
    logic [3:0] burst_len;
    logic [7:0] number;
    logic       number_valid;
    logic       number_ready;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]      seed;
        logic [1:0]      mode;
        logic [3:0]      blen;
        logic [3:0][7:0] beats;
        logic [7:0]      after;
        logic            same_cycle;
    } vec_t;

    vec_t vecs [7];

    stim_pattern_gen #(.WIDTH(8), .BURST_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .load_data    (load_data),
        .mode         (mode),
        .start        (start),
        .burst_len    (burst_len),
        .number       (number),
        .number_valid (number_valid),
        .number_ready (number_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Loads the seed (same cycle as start, or one cycle earlier) and starts a burst.
    task automatic launch(input logic [7:0] seed, input logic [1:0] m,
                          input logic [3:0] blen, input logic same_cycle);
        load      = 1'b1;
        load_data = seed;
        if (!same_cycle) begin
            tick();
            load = 1'b0;
        end
        start     = 1'b1;
        mode      = m;
        burst_len = blen;
        tick();
        start = 1'b0;
        load  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        number_ready = 1'b1;
        launch(v.seed, v.mode, v.blen, v.same_cycle);
        for (int i = 0; i < int'(v.blen); i++) begin
            check($sformatf("v%0d beat%0d number", idx, i), {24'h0, number}, {24'h0, v.beats[i]});
            check($sformatf("v%0d beat%0d valid", idx, i), {31'h0, number_valid}, 32'h1);
            tick();
        end
        check($sformatf("v%0d done", idx), {31'h0, done}, 32'h1);
        check($sformatf("v%0d valid_in_done", idx), {31'h0, number_valid}, 32'h0);
        check($sformatf("v%0d after", idx), {24'h0, number}, {24'h0, v.after});
        tick();
        check($sformatf("v%0d done_cleared", idx), {31'h0, done}, 32'h0);
        check($sformatf("v%0d busy_cleared", idx), {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int beats_seen;
        int busy_cycles;
        int done_pulses;
        int bad_words;

        vecs[0] = '{8'h81, 2'd0, 4'd3, {8'h00, 8'h06, 8'h03, 8'h81}, 8'h0C, 1'b1};
        vecs[1] = '{8'h01, 2'd1, 4'd2, {8'h00, 8'h00, 8'h80, 8'h01}, 8'h40, 1'b0};
        vecs[2] = '{8'hFE, 2'd2, 4'd3, {8'h00, 8'h00, 8'hFF, 8'hFE}, 8'h01, 1'b1};
        vecs[3] = '{8'h3C, 2'd3, 4'd2, {8'h00, 8'h00, 8'h3C, 8'h3C}, 8'h3C, 1'b0};
        vecs[4] = '{8'h81, 2'd1, 4'd3, {8'h00, 8'h60, 8'hC0, 8'h81}, 8'h30, 1'b1};
        vecs[5] = '{8'h7F, 2'd2, 4'd1, {8'h00, 8'h00, 8'h00, 8'h7F}, 8'h80, 1'b0};
        vecs[6] = '{8'h80, 2'd0, 4'd4, {8'h04, 8'h02, 8'h01, 8'h80}, 8'h08, 1'b1};

        reset_n      = 1'b0;
        load         = 1'b0;
        load_data    = 8'h00;
        mode         = 2'd0;
        start        = 1'b0;
        burst_len    = 4'd0;
        number_ready = 1'b0;
        repeat (2) tick();
        check("rst number", {24'h0, number}, 32'h01);
        check("rst valid", {31'h0, number_valid}, 32'h0);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: ROR from 01, two beats, consumer stalls three cycles.
        number_ready = 1'b0;
        launch(8'h01, 2'd1, 4'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d number", i), {24'h0, number}, 32'h01);
            check($sformatf("stall%0d valid", i), {31'h0, number_valid}, 32'h1);
            tick();
        end
        check("stall held after", {24'h0, number}, 32'h01);
        number_ready = 1'b1;
        tick();
        check("bp beat1 number", {24'h0, number}, 32'h80);
        check("bp beat1 valid", {31'h0, number_valid}, 32'h1);
        tick();
        check("bp done", {31'h0, done}, 32'h1);
        check("bp after", {24'h0, number}, 32'h40);
        tick();

        // Max burst: burst_len=0 means 16 beats of HOLD.
        launch(8'hA5, 2'd3, 4'd0, 1'b0);
        beats_seen  = 0;
        busy_cycles = 0;
        done_pulses = 0;
        bad_words   = 0;
        for (int i = 0; i < 40; i++) begin
            if (number_valid && number_ready) beats_seen++;
            if (number_valid && number !== 8'hA5) bad_words++;
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            tick();
        end
        check("max beats", beats_seen, 32'd16);
        check("max busy cycles", busy_cycles, 32'd17);
        check("max done pulses", done_pulses, 32'd1);
        check("max bad words", bad_words, 32'd0);

        // Controls asserted during RUN must be ignored.
        launch(8'h81, 2'd0, 4'd3, 1'b0);
        start     = 1'b1;
        load      = 1'b1;
        load_data = 8'h55;
        mode      = 2'd2;
        burst_len = 4'd1;
        check("ign beat0", {24'h0, number}, 32'h81);
        tick();
        check("ign beat1", {24'h0, number}, 32'h03);
        tick();
        check("ign beat2", {24'h0, number}, 32'h06);
        check("ign valid2", {31'h0, number_valid}, 32'h1);
        tick();
        check("ign done", {31'h0, done}, 32'h1);
        check("ign after", {24'h0, number}, 32'h0C);
        start = 1'b0;
        load  = 1'b0;
        tick();
        check("ign idle busy", {31'h0, busy}, 32'h0);
        check("ign idle number", {24'h0, number}, 32'h0C);

        // Reset mid-burst: outputs return to reset values without a clock edge.
        launch(8'h81, 2'd0, 4'd3, 1'b1);
        tick();
        check("pre-rst number", {24'h0, number}, 32'h03);
        reset_n = 1'b0;
        #1;
        check("async rst number", {24'h0, number}, 32'h01);
        check("async rst valid", {31'h0, number_valid}, 32'h0);
        check("async rst busy", {31'h0, busy}, 32'h0);
        check("async rst done", {31'h0, done}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post-rst valid", {31'h0, number_valid}, 32'h0);
        check("post-rst busy", {31'h0, busy}, 32'h0);
        check("post-rst done", {31'h0, done}, 32'h0);
        check("post-rst number", {24'h0, number}, 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
